// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter among NREQ byte
//   sources. A winner keeps the grant (packet lock) until it flags the last
//   byte, drops its request, or has sent MAX_BURST bytes. Each byte is handed
//   to the transmitter with a one-cycle tx_start, and the frame is tracked
//   through tx_busy before the next byte is issued.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous reset, active-low
//   req       in   [NREQ]   per-requester byte pending (held until acked)
//   req_data  in   [8*NREQ] byte for requester i at [8i+7:8i]
//   req_last  in   [NREQ]   pending byte ends the packet
//   grant     out  [NREQ]   one-hot current owner, zero when free
//   ack       out  [NREQ]   one-cycle pulse when the owner's byte is taken
//   tx_data   out  [8]      byte to the transmitter
//   tx_start  out           one-cycle start pulse to the transmitter
//   tx_busy   in            transmitter frame in progress
//   idle      out           high in IDLE with no grant
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              idle
);

  localparam int          IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n, ack_n;
  logic [7:0]      tx_data_n;
  logic            tx_start_n, idle_n;
  logic [IW-1:0]   ptr, ptr_n, owner, owner_n;
  logic [7:0]      burst_cnt, burst_cnt_n;
  logic            last_flag, last_flag_n;
  logic            hi_cnt, hi_cnt_n;

  logic [IW-1:0]   winner;
  logic            found;
  logic [NREQ-1:0] winner_oh;

  // Search ptr+1, ptr+2, ... modulo NREQ; the first requester hit wins.
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    winner_oh = '0;
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      int unsigned cand;
      cand = (32'(ptr) + k) % NREQ_U;
      if (!found && req[IW'(cand)]) begin
        found  = 1'b1;
        winner = IW'(cand);
      end
    end
    winner_oh[winner] = 1'b1;
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    ack_n       = '0;
    tx_data_n   = tx_data;
    tx_start_n  = 1'b0;
    idle_n      = idle;
    ptr_n       = ptr;
    owner_n     = owner;
    burst_cnt_n = burst_cnt;
    last_flag_n = last_flag;
    hi_cnt_n    = hi_cnt;

    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n     = winner_oh;
          owner_n     = winner;
          burst_cnt_n = '0;
          idle_n      = 1'b0;
          state_n     = SEND;
        end
      end
      SEND: begin
        if (!req[owner]) begin
          grant_n = '0;
          ptr_n   = owner;
          idle_n  = 1'b1;
          state_n = IDLE;
        end else if (!tx_busy) begin
          tx_data_n   = req_data[8*owner +: 8];
          tx_start_n  = 1'b1;
          ack_n       = grant;
          last_flag_n = req_last[owner];
          burst_cnt_n = burst_cnt + 8'd1;
          hi_cnt_n    = 1'b0;
          state_n     = WAIT_HI;
        end
      end
      WAIT_HI: begin
        // A transmitter that never raises busy is treated as already done
        // after two cycles so the arbiter cannot hang here.
        if (tx_busy || hi_cnt) begin
          state_n = WAIT_LO;
        end else begin
          hi_cnt_n = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_flag || (burst_cnt == 8'(MAX_BURST))) begin
            grant_n = '0;
            ptr_n   = owner;
            idle_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      ack       <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      idle      <= 1'b1;
      ptr       <= IW'(NREQ - 1);
      owner     <= '0;
      burst_cnt <= '0;
      last_flag <= 1'b0;
      hi_cnt    <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      ack       <= ack_n;
      tx_data   <= tx_data_n;
      tx_start  <= tx_start_n;
      idle      <= idle_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      burst_cnt <= burst_cnt_n;
      last_flag <= last_flag_n;
      hi_cnt    <= hi_cnt_n;
    end
  end

endmodule
